midi_disp_fmt: RTL
==================

Name: midi_disp_fmt

Overview:
Parses the serial MIDI byte stream from the UART receiver into complete channel-voice messages. Splits each completed message into six hex nibbles (status, data1, data2) and presents them, with per-digit valid strobes, to six downstream seven-segment decoder instances. Decoders hold their last value while their valid is low, so this block emits one-cycle update strobes only. Also keeps a message counter and flags protocol errors.

Parameters:
CHANNEL_FILTER_EN, 0, 1 = only messages whose channel nibble equals CHANNEL are displayed and counted.
CHANNEL, 4'h0, MIDI channel used when filtering is enabled.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
byte_in  in  8  received MIDI byte
byte_valid_in  in  1  one-cycle strobe; byte_in is valid; may be asserted back-to-back; no backpressure
digits_out  out  24  six nibbles: [23:16] status, [15:8] data1, [7:0] data2; digit 5 = [23:20] ... digit 0 = [3:0]
digit_valid_out  out  6  one-cycle update strobe per digit, bit i for digit i
msg_count_out  out  16  count of displayed messages, wraps 16'hFFFF -> 0
err_out  out  1  one-cycle pulse on a dropped data byte

Behaviour:
- Reset (async, active-high): all outputs 0; FSM to IDLE; running status cleared.
- Byte classes:
  - status = bit7 set, 0x80-0xEF
  - system common = 0xF0-0xF7
  - real-time = 0xF8-0xFF
  - data = bit7 clear
- Message length: 0xC0-0xDF have one data byte; other channel statuses have two.
- FSM states IDLE, WAIT_D1, WAIT_D2. All transitions happen only on byte_valid_in.
  - Channel status byte, any state -> latch status, set running status, go WAIT_D1. Any partial message is discarded silently.
  - System common, any state -> clear running status, go IDLE.
  - Real-time, any state -> ignored. State, latched bytes and running status are unchanged.
  - Data in IDLE with running status set -> treat as data1 under running status. This either completes a one-data-byte message or goes WAIT_D2.
  - Data in IDLE with no running status -> drop the byte, pulse err_out next cycle.
  - Data in WAIT_D1 -> latch data1. One-data-byte status: complete message, go IDLE. Otherwise go WAIT_D2.
  - Data in WAIT_D2 -> latch data2, complete message, go IDLE.
- Completion, for a byte accepted in cycle N. All of the following take effect in cycle N+1 (registered) and are then 0 again:
  - digits_out updated.
  - digit_valid_out = 6'b111111 for two-data-byte messages; 6'b111100 for one-data-byte messages, with digits_out[7:0] left unchanged.
  - msg_count_out increments.
- Channel filter: with CHANNEL_FILTER_EN=1 and a mismatching channel, parsing proceeds normally but completion produces no strobe, no digits_out update and no count.
- digits_out holds its value between completions.
- Data bits are stored as received; bit7 is always 0.
- Reset mid-message: partial message lost; first data byte after reset is an error.

Decomposition:
- Shared package midi_pkg:
  - status range constants (NOTE_OFF 0x8, NOTE_ON 0x9 ... PITCH_BEND 0xE, SYS_COMMON_BASE 0xF0, REALTIME_BASE 0xF8)
  - parser state enum
  - function returning data-byte count for a status nibble
- No sub-module. The top level instantiates this block plus six led_dec instances wired per digit.

Test Plan:
- Note-on 0x90,0x3C,0x64 -> cycle after 0x64: digits_out=24'h903C64, digit_valid_out=6'h3F for one cycle, msg_count_out=1.
- Running status: after previous, send 0x40,0x00 -> digits_out=24'h904000, valid 6'h3F, count=2.
- Real-time interleave 0x90,0xF8,0x3C,0xFE,0x64 -> identical to the first scenario. Also abort case: 0x90,0x3C,0x80,0x3C,0x00 -> only 24'h803C00 displayed, no err.
- Program change 0xC5,0x07 after 24'h903C64 -> digits_out=24'hC50764, valid 6'b111100. Then 0xF0, then 0x10 -> err_out pulse, no valid.
- CHANNEL_FILTER_EN=1, CHANNEL=1: 0x90,0x3C,0x64 -> no strobe, count 0. Then 0x91,0x3C,0x64 -> digits_out=24'h913C64, count=1.
- Reset asserted between 0x3C and 0x64 -> outputs 0 immediately. Following 0x64 -> err_out pulse. Counter wrap: preload 16'hFFFF by 65535 messages -> next message gives 0.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state and byte classification helpers.
package midi_pkg;

  // Channel-voice status high nibbles
  localparam logic [3:0] NOTE_OFF         = 4'h8;
  localparam logic [3:0] NOTE_ON          = 4'h9;
  localparam logic [3:0] POLY_PRESSURE    = 4'hA;
  localparam logic [3:0] CONTROL_CHANGE   = 4'hB;
  localparam logic [3:0] PROGRAM_CHANGE   = 4'hC;
  localparam logic [3:0] CHANNEL_PRESSURE = 4'hD;
  localparam logic [3:0] PITCH_BEND       = 4'hE;

  // System message ranges
  localparam logic [7:0] SYS_COMMON_BASE  = 8'hF0;
  localparam logic [7:0] REALTIME_BASE    = 8'hF8;

  // Digit strobe patterns for a completed message
  localparam logic [5:0] VALID_TWO_DATA   = 6'b111111;
  localparam logic [5:0] VALID_ONE_DATA   = 6'b111100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } parse_state_e;

  typedef enum logic [1:0] {
    BC_DATA     = 2'd0,
    BC_STATUS   = 2'd1,
    BC_SYS_COMM = 2'd2,
    BC_REALTIME = 2'd3
  } byte_class_e;

  // Number of data bytes that follow a channel status with this high nibble
  function automatic logic [1:0] data_len(input logic [3:0] status_hi);
    if (status_hi == PROGRAM_CHANGE || status_hi == CHANNEL_PRESSURE)
      return 2'd1;
    return 2'd2;
  endfunction

  // Sort a received byte into data / channel status / system common / real-time
  function automatic byte_class_e classify(input logic [7:0] b);
    if (!b[7])                  return BC_DATA;
    if (b >= REALTIME_BASE)     return BC_REALTIME;
    if (b >= SYS_COMMON_BASE)   return BC_SYS_COMM;
    return BC_STATUS;
  endfunction

endpackage

// File: rtl/midi_disp_fmt.sv
// MIDI channel-voice parser feeding six hex digit displays.
// Tracks running status, ignores real-time bytes, and presents each completed
// message as status/data1/data2 nibbles with one-cycle per-digit update strobes.
module midi_disp_fmt
  import midi_pkg::*;
#(
  parameter bit         CHANNEL_FILTER_EN = 1'b0,
  parameter logic [3:0] CHANNEL           = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  output logic [23:0] digits_out,
  output logic [5:0]  digit_valid_out,
  output logic [15:0] msg_count_out,
  output logic        err_out
);

  parse_state_e state;
  logic [7:0]   status_q;
  logic [6:0]   data1_q;
  logic         run_q;      // running status is valid

  byte_class_e  cls;
  logic         one_data;   // latched status carries a single data byte
  logic         chan_ok;

  logic         done;       // a message completes with this byte
  logic         done_two;   // ...and it is a two-data-byte message
  logic         drop;       // data byte with nothing to attach to
  logic [6:0]   msg_d1;
  logic [6:0]   msg_d2;

  assign cls      = classify(byte_in);
  assign one_data = (data_len(status_q[7:4]) == 2'd1);
  assign chan_ok  = !CHANNEL_FILTER_EN || (status_q[3:0] == CHANNEL);

  // Decide whether the incoming data byte completes a message or is dropped
  always_comb begin
    done     = 1'b0;
    done_two = 1'b0;
    drop     = 1'b0;
    msg_d1   = data1_q;
    msg_d2   = byte_in[6:0];
    if (byte_valid_in && cls == BC_DATA) begin
      unique case (state)
        IDLE: begin
          if (!run_q) begin
            drop = 1'b1;
          end else if (one_data) begin
            done   = 1'b1;
            msg_d1 = byte_in[6:0];
          end
        end
        WAIT_D1: begin
          if (one_data) begin
            done   = 1'b1;
            msg_d1 = byte_in[6:0];
          end
        end
        WAIT_D2: begin
          done     = 1'b1;
          done_two = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Parser FSM: status latch, running status and first data byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      status_q <= 8'h00;
      data1_q  <= 7'h00;
      run_q    <= 1'b0;
    end else if (byte_valid_in) begin
      unique case (cls)
        BC_STATUS: begin
          status_q <= byte_in;
          run_q    <= 1'b1;
          state    <= WAIT_D1;
        end
        BC_SYS_COMM: begin
          run_q <= 1'b0;
          state <= IDLE;
        end
        BC_REALTIME: ;
        BC_DATA: begin
          unique case (state)
            IDLE, WAIT_D1: begin
              // IDLE with no running status is a drop; state stays IDLE
              if ((state == WAIT_D1 || run_q) && !one_data) begin
                data1_q <= byte_in[6:0];
                state   <= WAIT_D2;
              end else begin
                state <= IDLE;
              end
            end
            WAIT_D2: state <= IDLE;
            default: state <= IDLE;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Registered display outputs, strobes, message counter and error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_out      <= 24'h000000;
      digit_valid_out <= 6'b000000;
      msg_count_out   <= 16'h0000;
      err_out         <= 1'b0;
    end else begin
      digit_valid_out <= 6'b000000;
      err_out         <= drop;
      if (done && chan_ok) begin
        digits_out[23:8] <= {status_q, 1'b0, msg_d1};
        if (done_two) begin
          digits_out[7:0] <= {1'b0, msg_d2};
          digit_valid_out <= VALID_TWO_DATA;
        end else begin
          digit_valid_out <= VALID_ONE_DATA;
        end
        msg_count_out <= msg_count_out + 16'd1;
      end
    end
  end

endmodule
